// File: rtl/ik_iter_ctrl.sv
// Iteration controller for the ik_swift DLS step core: runs repeated solver
// passes, feeds each pass's joint vector back, and stops on convergence, limit or abort.
module ik_iter_ctrl #(
  parameter int unsigned JOINTS  = 6,
  parameter int unsigned DW      = 21,
  parameter int unsigned DELTA_W = 36,
  parameter int unsigned IW      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [JOINTS*DW-1:0]        init_dh,
  input  logic [IW-1:0]               max_iter,
  input  logic [DW-2:0]               tol,
  output logic                        busy,
  output logic                        done,
  output logic                        converged,
  output logic [IW-1:0]               iter_count,
  output logic [JOINTS*DW-1:0]        dh_result,
  output logic                        core_rst,
  output logic                        core_en,
  output logic [JOINTS*DW-1:0]        core_dh_in,
  input  logic                        core_done,
  input  logic [JOINTS*DW-1:0]        core_dh_out,
  input  logic [JOINTS*DELTA_W-1:0]   core_delta
);

  localparam int unsigned VW = JOINTS * DW;
  localparam int unsigned TW = DW - 1;
  localparam int unsigned HW = DELTA_W - DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_CHECK,
    S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [VW-1:0] dh_q, dh_d;
  logic [VW-1:0] cap_q, cap_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [IW-1:0] lim_q, lim_d;
  logic [TW-1:0] tol_q, tol_d;
  logic          within_q, within_d;
  logic          conv_q, conv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          all_within;
  logic          unused_delta_hi;
  logic [IW-1:0] iter_inc;

  // Two's-complement magnitude kept DW bits wide, so the most negative code stays out of range.
  function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] x);
    return x[DW-1] ? ((~x) + DW'(1)) : x;
  endfunction

  always_comb begin
    all_within      = 1'b1;
    unused_delta_hi = 1'b0;
    for (int j = 0; j < int'(JOINTS); j++) begin
      if (abs_dw(core_delta[j*DELTA_W +: DW]) > {1'b0, tol_q}) all_within = 1'b0;
      unused_delta_hi = unused_delta_hi ^ (^core_delta[j*DELTA_W+DW +: HW]);
    end
  end

  assign iter_inc = iter_q + IW'(1);

  // Next-state and register update decode.
  always_comb begin
    state_d  = state_q;
    dh_d     = dh_q;
    cap_d    = cap_q;
    iter_d   = iter_q;
    lim_d    = lim_q;
    tol_d    = tol_q;
    within_d = within_q;
    conv_d   = conv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dh_d    = init_dh;
          lim_d   = (max_iter == '0) ? IW'(1) : max_iter;
          tol_d   = tol;
          iter_d  = '0;
          conv_d  = 1'b0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (abort) begin
          conv_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          conv_d  = 1'b0;
          state_d = S_FINISH;
        end else if (core_done) begin
          cap_d    = core_dh_out;
          within_d = all_within;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          conv_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          dh_d   = cap_q;
          iter_d = iter_inc;
          if (within_q) begin
            conv_d  = 1'b1;
            state_d = S_FINISH;
          end else if (iter_inc == lim_q) begin
            conv_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dh_q     <= '0;
      cap_q    <= '0;
      iter_q   <= '0;
      lim_q    <= '0;
      tol_q    <= '0;
      within_q <= 1'b0;
      conv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dh_q     <= dh_d;
      cap_q    <= cap_d;
      iter_q   <= iter_d;
      lim_q    <= lim_d;
      tol_q    <= tol_d;
      within_q <= within_d;
      conv_q   <= conv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Core handshake is decoded so the core sees reset for the whole CLR cycle and during rst_n.
  assign core_rst   = ~rst_n | (state_q == S_CLR);
  assign core_en    = rst_n & (state_q == S_RUN);
  assign core_dh_in = dh_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign dh_result  = dh_q;

endmodule

// File: tb/tb_ik_iter_ctrl.sv
// Bench for ik_iter_ctrl: a cycle-accurate ik_swift stand-in feeds per-pass data
// and a pass-level reference model predicts the outcome of each solve.
module tb_ik_iter_ctrl;

  localparam int unsigned JOINTS  = 6;
  localparam int unsigned DW      = 21;
  localparam int unsigned DELTA_W = 36;
  localparam int unsigned IW      = 8;
  localparam int unsigned VW      = JOINTS * DW;
  localparam int unsigned XW      = JOINTS * DELTA_W;
  localparam int unsigned TW      = DW - 1;
  localparam int unsigned HW      = DELTA_W - DW;
  localparam int          PASS_CYC = 251;
  localparam int          MAXP     = 16;
  localparam int          LIMIT    = PASS_CYC * MAXP + 20;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [VW-1:0] init_dh;
  logic [IW-1:0] max_iter;
  logic [TW-1:0] tol;
  logic          busy, done, converged;
  logic [IW-1:0] iter_count;
  logic [VW-1:0] dh_result, core_dh_in, core_dh_out;
  logic          core_rst, core_en, core_done;
  logic [XW-1:0] core_delta;

  int n_cmp = 0;
  int n_bad = 0;

  logic [VW-1:0] pass_dh [MAXP];
  logic [XW-1:0] pass_dx [MAXP];
  logic [VW-1:0] init_v;
  int            clr_cnt;
  int            base;
  int            pidx;
  logic [8:0]    ccnt;

  always #5 clk = ~clk;

  ik_iter_ctrl #(.JOINTS(JOINTS), .DW(DW), .DELTA_W(DELTA_W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .init_dh(init_dh), .max_iter(max_iter), .tol(tol),
    .busy(busy), .done(done), .converged(converged),
    .iter_count(iter_count), .dh_result(dh_result),
    .core_rst(core_rst), .core_en(core_en), .core_dh_in(core_dh_in),
    .core_done(core_done), .core_dh_out(core_dh_out), .core_delta(core_delta)
  );

  // Core stand-in: counts 0..248 while enabled, done flag set at 248, cleared when disabled.
  always_ff @(posedge clk) begin
    if (core_rst) begin
      ccnt      <= '0;
      core_done <= 1'b0;
    end else if (core_en) begin
      if (ccnt == 9'd247) core_done <= 1'b1;
      if (ccnt != 9'd248) ccnt <= ccnt + 9'd1;
    end else begin
      core_done <= 1'b0;
    end
    if (!rst_n) clr_cnt <= 0;
    else if (core_rst) clr_cnt <= clr_cnt + 1;
  end

  assign pidx        = clr_cnt - base - 1;
  assign core_dh_out = (pidx >= 0 && pidx < MAXP) ? pass_dh[pidx[3:0]] : '0;
  assign core_delta  = (pidx >= 0 && pidx < MAXP) ? pass_dx[pidx[3:0]] : '0;

  // One pass of core data: joint k carries delta v, the others lie within +/-bound.
  task automatic fill_pass(input int p, input int v, input int bound);
    logic [VW-1:0] dh;
    logic [XW-1:0] dx;
    int k;
    int val;
    k = int'($urandom_range(JOINTS - 1));
    for (int j = 0; j < int'(JOINTS); j++) begin
      val = (j == k) ? v : int'($urandom_range(2 * bound)) - bound;
      dx[j*DELTA_W +: DELTA_W] = {HW'($urandom), DW'(val)};
      dh[j*DW +: DW] = DW'($urandom);
    end
    pass_dh[p] = dh;
    pass_dx[p] = dx;
  endtask

  // Pass-level reference: stop at the first pass whose every |delta| <= tol, or at the limit.
  function automatic void ref_solve(input int mi, input int tl, output int n, output bit conv);
    int lim;
    int x;
    bit ok;
    lim  = (mi == 0) ? 1 : mi;
    n    = 0;
    conv = 1'b0;
    for (int p = 0; p < MAXP; p++) begin
      n  = p + 1;
      ok = 1'b1;
      for (int j = 0; j < int'(JOINTS); j++) begin
        x = int'($signed(pass_dx[p][j*DELTA_W +: DW]));
        if (x < 0) x = -x;
        if (x > tl) ok = 1'b0;
      end
      if (ok) begin
        conv = 1'b1;
        return;
      end
      if (n == lim) return;
    end
  endfunction

  // Pulse start; on return the start edge has just passed (sampling point #1 after it).
  task automatic kick(input int mi, input int tl, input bit with_abort);
    @(posedge clk);
    #1;
    init_v   = {$urandom, $urandom, $urandom, $urandom};
    base     = clr_cnt;
    init_dh  = init_v;
    max_iter = IW'(mi);
    tol      = TW'(tl);
    start    = 1'b1;
    abort    = with_abort;
    @(posedge clk);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
    init_dh  = {$urandom, $urandom, $urandom, $urandom};
    max_iter = IW'($urandom);
    tol      = TW'($urandom);
  endtask

  task automatic run_solve(input int mi, input int tl, input bit with_abort, input int restart_at,
                           output int edges, output bit to, output logic busy_a,
                           output logic done_a, output logic [3:0] early, output bit dh_ok);
    logic [VW-1:0] prev_dh;
    logic          prev_en;
    kick(mi, tl, with_abort);
    early    = '0;
    early[3] = core_rst;
    early[2] = core_en;
    edges    = 0;
    to       = 1'b1;
    dh_ok    = 1'b1;
    prev_en  = 1'b0;
    prev_dh  = core_dh_in;
    while (edges < LIMIT) begin
      if (edges == restart_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
      if (edges == 1) begin
        early[1] = core_rst;
        early[0] = core_en;
      end
      if (core_dh_in !== dh_result) dh_ok = 1'b0;
      if (core_en && prev_en && core_dh_in !== prev_dh) dh_ok = 1'b0;
      prev_en = core_en;
      prev_dh = core_dh_in;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    busy_a = busy;
    done_a = done;
  endtask

  task automatic test_solve(input string name, input int mi, input int tl,
                            input bit with_abort, input int restart_at);
    int            n;
    bit            conv;
    int            edges;
    bit            to;
    bit            dh_ok;
    logic          busy_a;
    logic          done_a;
    logic [3:0]    early;
    logic [VW-1:0] exp_dh;
    ref_solve(mi, tl, n, conv);
    exp_dh = pass_dh[n-1];
    run_solve(mi, tl, with_abort, restart_at, edges, to, busy_a, done_a, early, dh_ok);
    n_cmp++;
    if (to !== 1'b0) begin
      n_bad++;
      $display("FAIL %s timeout: no done within %0d cycles (expected after %0d)", name, LIMIT, PASS_CYC * n);
    end
    n_cmp++;
    if (edges !== PASS_CYC * n) begin
      n_bad++;
      $display("FAIL %s done_latency: got %0d expected %0d", name, edges, PASS_CYC * n);
    end
    n_cmp++;
    if (converged !== conv) begin
      n_bad++;
      $display("FAIL %s converged: got %b expected %b", name, converged, conv);
    end
    n_cmp++;
    if (iter_count !== IW'(n)) begin
      n_bad++;
      $display("FAIL %s iter_count: got %0d expected %0d", name, iter_count, n);
    end
    n_cmp++;
    if (dh_result !== exp_dh) begin
      n_bad++;
      $display("FAIL %s dh_result: got %h expected %h", name, dh_result, exp_dh);
    end
    n_cmp++;
    if ({busy_a, done_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s after_done busy,done: got %b expected 00", name, {busy_a, done_a});
    end
    n_cmp++;
    if (early !== 4'b1001) begin
      n_bad++;
      $display("FAIL %s clr_run rst,en,rst,en: got %b expected 1001", name, early);
    end
    n_cmp++;
    if (dh_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s core_dh_in stability: got %b expected 1", name, dh_ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    init_dh = '0; max_iter = '0; tol = '0; base = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, converged, iter_count, dh_result, core_en, core_rst} !== {3'b000, IW'(0), VW'(0), 2'b01}) begin
      n_bad++;
      $display("FAIL reset outputs: got b%b d%b c%b it%0d en%b rst%b expected 0 0 0 0 0 1",
               busy, done, converged, iter_count, core_en, core_rst);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({core_rst, core_en, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle core_rst,core_en,busy: got %b expected 000", {core_rst, core_en, busy});
    end
  endtask

  task automatic test_convergence();
    fill_pass(0, $urandom_range(1) ? 1000 : -1000, 4);
    fill_pass(1, $urandom_range(1) ? 500 : -500, 4);
    fill_pass(2, $urandom_range(1) ? 3 : -3, 4);
    for (int p = 3; p < MAXP; p++) fill_pass(p, 999, 4);
    test_solve("converge", 10, 4, 1'b0, -1);
  endtask

  task automatic test_iter_limit();
    for (int p = 0; p < MAXP; p++) fill_pass(p, 1, 0);
    test_solve("limit2", 2, 0, 1'b0, -1);
    test_solve("limit0", 0, 0, 1'b0, -1);
  endtask

  task automatic test_tol_edges();
    for (int p = 0; p < MAXP; p++) fill_pass(p, 5000, 100);
    fill_pass(0, 100, 100);
    test_solve("tol_pos100", 3, 100, 1'b0, -1);
    fill_pass(0, -100, 100);
    test_solve("tol_neg100", 3, 100, 1'b0, -1);
    fill_pass(0, -101, 100);
    test_solve("tol_neg101", 1, 100, 1'b0, -1);
    fill_pass(0, -(1 << 20), 1000);
    test_solve("tol_mostneg", 1, (1 << 20) - 1, 1'b0, -1);
  endtask

  task automatic test_random();
    int tl;
    int mi;
    int v;
    for (int t = 0; t < 6; t++) begin
      tl = int'($urandom_range(1000));
      mi = int'($urandom_range(4));
      for (int p = 0; p < MAXP; p++) begin
        v = ($urandom_range(2) == 0) ? int'($urandom_range(tl)) : tl + 1 + int'($urandom_range(5000));
        if ($urandom_range(1) == 1) v = -v;
        fill_pass(p, v, tl);
      end
      test_solve($sformatf("random%0d", t), mi, tl, 1'b0, -1);
    end
  endtask

  task automatic test_abort();
    int pulses;
    for (int p = 0; p < MAXP; p++) fill_pass(p, 1000, 0);
    // Abort at RUN cycle 100 of pass 2.
    kick(5, 0, 1'b0);
    repeat (351) @(posedge clk);
    #1;
    n_cmp++;
    if (core_en !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_run pre core_en: got %b expected 1", core_en);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_cmp++;
    if ({core_en, done, converged, iter_count} !== {3'b010, IW'(1)} || dh_result !== pass_dh[0]) begin
      n_bad++;
      $display("FAIL abort_run en,done,conv,iter: got %b%b%b %0d expected 010 1 (dh match %b)",
               core_en, done, converged, iter_count, dh_result === pass_dh[0]);
    end
    pulses = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_run extra done pulses/busy: got %0d/%b expected 0/0", pulses, busy);
    end
    // Abort together with core_done: pass discarded.
    kick(5, 0, 1'b0);
    repeat (249) @(posedge clk);
    #1;
    n_cmp++;
    if (core_done !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_done pre core_done: got %b expected 1", core_done);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_cmp++;
    if ({done, converged, iter_count} !== {2'b10, IW'(0)} || dh_result !== init_v) begin
      n_bad++;
      $display("FAIL abort_done done,conv,iter: got %b%b %0d expected 10 0 (dh match %b)",
               done, converged, iter_count, dh_result === init_v);
    end
    // Abort in CHECK: no update of dh_result or iter_count.
    kick(5, 0, 1'b0);
    repeat (250) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_cmp++;
    if ({done, converged, iter_count} !== {2'b10, IW'(0)} || dh_result !== init_v) begin
      n_bad++;
      $display("FAIL abort_check done,conv,iter: got %b%b %0d expected 10 0 (dh match %b)",
               done, converged, iter_count, dh_result === init_v);
    end
    // Abort in CLR.
    kick(5, 0, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_cmp++;
    if ({done, core_en, iter_count} !== {2'b10, IW'(0)}) begin
      n_bad++;
      $display("FAIL abort_clr done,en,iter: got %b%b %0d expected 10 0", done, core_en, iter_count);
    end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    for (int p = 0; p < MAXP; p++) fill_pass(p, 1000, 0);
    kick(3, 0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (core_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_reset core_rst: got %b expected 1", core_rst);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    n_cmp++;
    if ({busy, converged, iter_count, dh_result, core_en, core_rst} !== {2'b00, IW'(0), VW'(0), 2'b01} || pulses !== 0) begin
      n_bad++;
      $display("FAIL midrun_reset outputs: got b%b c%b it%0d en%b rst%b pulses%0d expected 0 0 0 0 1 0",
               busy, converged, iter_count, core_en, core_rst, pulses);
    end
    rst_n = 1'b1;
    fill_pass(0, 700, 50);
    fill_pass(1, -20, 50);
    test_solve("after_reset", 4, 50, 1'b0, -1);
  endtask

  task automatic test_start_handling();
    for (int p = 0; p < MAXP; p++) fill_pass(p, 1, 0);
    test_solve("start_busy", 2, 0, 1'b0, 300);
    fill_pass(0, 900, 10);
    fill_pass(1, 10, 10);
    test_solve("start_abort_idle", 3, 10, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_convergence();
    test_iter_limit();
    test_tol_edges();
    test_abort();
    test_reset_midrun();
    test_start_handling();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
